// File: rtl/arc4_seq_ctrl_if.sv
// Handshake and S-memory bundle between the ARC4 sequencer, its three engines
// and the task-level top.
interface arc4_seq_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              en;
    logic              rdy;
    logic              done;
    logic              err;

    logic              init_en;
    logic              init_rdy;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_wrdata;
    logic              init_wren;

    logic              ksa_en;
    logic              ksa_rdy;
    logic [ADDR_W-1:0] ksa_addr;
    logic [DATA_W-1:0] ksa_wrdata;
    logic              ksa_wren;

    logic              prga_en;
    logic              prga_rdy;
    logic [ADDR_W-1:0] prga_addr;
    logic [DATA_W-1:0] prga_wrdata;
    logic              prga_wren;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wrdata;
    logic              s_wren;

    modport master (
        input  en,
        output rdy, done, err,
        output init_en,
        input  init_rdy, init_addr, init_wrdata, init_wren,
        output ksa_en,
        input  ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
        output prga_en,
        input  prga_rdy, prga_addr, prga_wrdata, prga_wren,
        output s_addr, s_wrdata, s_wren
    );

    modport slave (
        output en,
        input  rdy, done, err,
        input  init_en,
        output init_rdy, init_addr, init_wrdata, init_wren,
        input  ksa_en,
        output ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
        input  prga_en,
        output prga_rdy, prga_addr, prga_wrdata, prga_wren,
        input  s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/arc4_seq_ctrl.sv
// ARC4 top-level sequencer: runs init, KSA and PRGA in order, owns the single
// S-memory port on behalf of the running engine, and watchdogs stalled engines.
module arc4_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    arc4_seq_ctrl_if.master bus
);
    localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, INIT_GO, INIT_LO, INIT_HI,
        KSA_GO, KSA_LO, KSA_HI,
        PRGA_GO, PRGA_LO, PRGA_HI,
        FAULT
    } state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_KSA, OWN_PRGA} owner_t;

    state_t            state, state_next;
    owner_t            owner, owner_next;
    logic [WD_W-1:0]   wd, wd_next;
    logic              wd_hit;
    logic              accept;
    logic              done_q, err_q;
    logic              init_go, ksa_go, prga_go;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wrdata;
    logic              mux_wren;

    assign wd_hit = (wd == WD_LAST);
    assign accept = (state == IDLE) && bus.en;

    always_comb begin
        state_next = state;
        wd_next    = wd;
        init_go    = 1'b0;
        ksa_go     = 1'b0;
        prga_go    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_next = INIT_GO;
                    wd_next    = '0;
                end
            end
            FAULT: state_next = FAULT;
            default: begin
                // The watchdog outranks any progress made in its final cycle.
                if (wd_hit) begin
                    state_next = FAULT;
                end else begin
                    wd_next = wd + 1'b1;
                    case (state)
                        INIT_GO: if (bus.init_rdy) begin
                            init_go    = 1'b1;
                            state_next = INIT_LO;
                        end
                        INIT_LO: if (!bus.init_rdy) state_next = INIT_HI;
                        INIT_HI: if (bus.init_rdy) begin
                            state_next = KSA_GO;
                            wd_next    = '0;
                        end
                        KSA_GO: if (bus.ksa_rdy) begin
                            ksa_go     = 1'b1;
                            state_next = KSA_LO;
                        end
                        KSA_LO: if (!bus.ksa_rdy) state_next = KSA_HI;
                        KSA_HI: if (bus.ksa_rdy) begin
                            state_next = PRGA_GO;
                            wd_next    = '0;
                        end
                        PRGA_GO: if (bus.prga_rdy) begin
                            prga_go    = 1'b1;
                            state_next = PRGA_LO;
                        end
                        PRGA_LO: if (!bus.prga_rdy) state_next = PRGA_HI;
                        PRGA_HI: if (bus.prga_rdy) begin
                            state_next = IDLE;
                            wd_next    = '0;
                        end
                        default: state_next = FAULT;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        owner_next = OWN_NONE;
        case (state_next)
            INIT_GO, INIT_LO, INIT_HI: owner_next = OWN_INIT;
            KSA_GO, KSA_LO, KSA_HI:    owner_next = OWN_KSA;
            PRGA_GO, PRGA_LO, PRGA_HI: owner_next = OWN_PRGA;
            default:                   owner_next = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= OWN_NONE;
            wd     <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            wd    <= wd_next;
            if (accept)
                done_q <= 1'b0;
            else if (state == PRGA_HI && state_next == IDLE)
                done_q <= 1'b1;
            if (accept)
                err_q <= 1'b0;
            else if (state_next == FAULT)
                err_q <= 1'b1;
        end
    end

    // Owner is registered alongside state, so the mux adds no latency to engine traffic.
    always_comb begin
        mux_addr   = '0;
        mux_wrdata = '0;
        mux_wren   = 1'b0;
        case (owner)
            OWN_INIT: begin
                mux_addr   = bus.init_addr;
                mux_wrdata = bus.init_wrdata;
                mux_wren   = bus.init_wren;
            end
            OWN_KSA: begin
                mux_addr   = bus.ksa_addr;
                mux_wrdata = bus.ksa_wrdata;
                mux_wren   = bus.ksa_wren;
            end
            OWN_PRGA: begin
                mux_addr   = bus.prga_addr;
                mux_wrdata = bus.prga_wrdata;
                mux_wren   = bus.prga_wren;
            end
            default: ;
        endcase
    end

    assign bus.rdy      = (state == IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    // Start pulses are gated by reset so an aborted run issues nothing further.
    assign bus.init_en  = init_go & rst_n;
    assign bus.ksa_en   = ksa_go & rst_n;
    assign bus.prga_en  = prga_go & rst_n;
    assign bus.s_addr   = mux_addr;
    assign bus.s_wrdata = mux_wrdata;
    assign bus.s_wren   = mux_wren;
endmodule

// File: tb/tb_arc4_seq_ctrl.sv
// Bench for arc4_seq_ctrl: stub engines, a phase-level reference model checked
// every cycle, and directed scenarios with hand-computed timing expectations.
module tb_arc4_seq_ctrl;
    localparam int TO = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arc4_seq_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    arc4_seq_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic       en_in = 1'b0;
    logic       e_rdy  [3];
    logic [7:0] e_addr [3];
    logic [7:0] e_wd   [3];
    logic       e_wren [3];
    logic [2:0] en_o;

    assign bus.en          = en_in;
    assign bus.init_rdy    = e_rdy[0];
    assign bus.init_addr   = e_addr[0];
    assign bus.init_wrdata = e_wd[0];
    assign bus.init_wren   = e_wren[0];
    assign bus.ksa_rdy     = e_rdy[1];
    assign bus.ksa_addr    = e_addr[1];
    assign bus.ksa_wrdata  = e_wd[1];
    assign bus.ksa_wren    = e_wren[1];
    assign bus.prga_rdy    = e_rdy[2];
    assign bus.prga_addr   = e_addr[2];
    assign bus.prga_wrdata = e_wd[2];
    assign bus.prga_wren   = e_wren[2];
    assign en_o = {bus.prga_en, bus.ksa_en, bus.init_en};

    // Stub configuration: mode 0 = busy for busy_len cycles, 1 = stuck busy, 2 = never leaves ready.
    int   busy_len [3];
    int   mode     [3];
    bit   jitter   = 1'b0;
    bit   ksa_iso  = 1'b0;
    bit   stub_clr = 1'b0;
    int   cnt      [3];
    bit   stuck    [3];
    logic [2:0] en_smp = '0;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    bit mv = 1'b0;
    bit m_busy = 1'b0, m_fault = 1'b0, m_done = 1'b0;
    int m_ph = 0, m_st = 0, m_wd = 0;

    int n_en [3];
    int en_cyc [3];
    int order_q [$];
    int done_cyc = -1, err_cyc = -1, acc_cyc = -1;
    int hit_cnt = 0, n_done = 0;
    bit prev_done = 1'b0, prev_err = 1'b0;

    initial begin
        for (int e = 0; e < 3; e++) begin
            e_rdy[e] = 1'b1; e_addr[e] = '0; e_wd[e] = '0; e_wren[e] = 1'b0;
            cnt[e] = 0; stuck[e] = 1'b0; busy_len[e] = 1; mode[e] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int e = 0; e < 3; e++) begin
                if (stub_clr) begin
                    cnt[e] = 0; stuck[e] = 1'b0; e_rdy[e] = 1'b1;
                end else if (en_smp[e] && mode[e] != 2) begin
                    e_rdy[e] = 1'b0;
                    if (mode[e] == 1) stuck[e] = 1'b1;
                    else cnt[e] = busy_len[e];
                end else if (stuck[e]) begin
                    e_rdy[e] = 1'b0;
                end else if (cnt[e] > 0) begin
                    cnt[e]--;
                    e_rdy[e] = (cnt[e] == 0);
                end else begin
                    e_rdy[e] = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                e_addr[e] = 8'($urandom);
                e_wd[e]   = 8'($urandom);
                e_wren[e] = 1'($urandom);
            end
            if (ksa_iso) begin
                e_addr[0] = 8'hAA; e_wren[0] = 1'b1;
                e_addr[2] = 8'hBB; e_wren[2] = 1'b1;
                e_addr[1] = {1'b0, e_addr[1][6:0]};
            end
            stub_clr = 1'b0;
        end
    end

    task automatic summary_and_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Reference: which phase is running, how far its handshake has got, and how long it has been busy.
    always @(negedge clk) begin
        logic [22:0] exp_v, act_v;
        logic [2:0]  ee;
        logic        ew, er;
        logic [7:0]  ea, ed;
        cyc++;
        en_smp = en_o;
        if (mv) begin
            ee = '0; ew = 1'b0; ea = '0; ed = '0;
            if (m_busy) begin
                if (m_st == 0 && e_rdy[m_ph] && m_wd != TO - 1 && rst_n) ee[m_ph] = 1'b1;
                ea = e_addr[m_ph]; ed = e_wd[m_ph]; ew = e_wren[m_ph];
            end
            exp_v = {!m_busy && !m_fault, m_done, m_fault, ee[0], ee[1], ee[2], ew, ea, ed};
            act_v = {bus.rdy, bus.done, bus.err, bus.init_en, bus.ksa_en, bus.prga_en,
                     bus.s_wren, bus.s_addr, bus.s_wrdata};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle %0d outputs {rdy,done,err,init_en,ksa_en,prga_en,wren,addr,wrdata}: got %h expected %h",
                         cyc, act_v, exp_v);
                if (errors > 40) summary_and_finish();
            end
        end
        for (int e = 0; e < 3; e++) begin
            if (en_o[e]) begin
                n_en[e]++; en_cyc[e] = cyc; order_q.push_back(e);
            end
        end
        if (bus.done && !prev_done) begin done_cyc = cyc; n_done++; end
        if (bus.err && !prev_err) err_cyc = cyc;
        prev_done = bus.done;
        prev_err  = bus.err;
        if (n_en[1] > 0 && n_en[2] == 0 && bus.s_wren && (bus.s_addr == 8'hAA || bus.s_addr == 8'hBB))
            hit_cnt++;

        if (!rst_n) begin
            mv = 1'b1; m_busy = 1'b0; m_fault = 1'b0; m_done = 1'b0;
        end else if (mv && !m_fault) begin
            if (!m_busy) begin
                if (en_in) begin
                    m_busy = 1'b1; m_ph = 0; m_st = 0; m_wd = 0; m_done = 1'b0; acc_cyc = cyc;
                end
            end else if (m_wd == TO - 1) begin
                m_fault = 1'b1; m_busy = 1'b0;
            end else begin
                er = e_rdy[m_ph];
                m_wd++;
                if (m_st == 0) begin
                    if (er) m_st = 1;
                end else if (m_st == 1) begin
                    if (!er) m_st = 2;
                end else if (er) begin
                    if (m_ph == 2) begin
                        m_busy = 1'b0; m_done = 1'b1;
                    end else begin
                        m_ph++; m_st = 0; m_wd = 0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        for (int e = 0; e < 3; e++) begin n_en[e] = 0; en_cyc[e] = -1; end
        order_q.delete();
        done_cyc = -1; err_cyc = -1; acc_cyc = -1; hit_cnt = 0;
    endtask

    task automatic do_reset();
        en_in = 1'b0;
        stub_clr = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int kind, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            tick(1);
            if (kind == 0)      hit = (done_cyc >= 0);
            else if (kind == 1) hit = (err_cyc >= 0);
            else                hit = (n_en[1] > 0);
        end
        check(name, int'(hit), 1);
    endtask

    task automatic pulse_en();
        en_in = 1'b1;
        tick(1);
        en_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int e = 0; e < 3; e++) begin n_en[e] = 0; en_cyc[e] = -1; end
        tick(2);
        do_reset();
        tick(1);
        check("reset_rdy", int'(bus.rdy), 1);
        check("reset_done", int'(bus.done), 0);
        check("reset_err", int'(bus.err), 0);
        check("reset_s_wren", int'(bus.s_wren), 0);

        // Full run with 256/1536/512-cycle engines; non-owners hammer 0xAA/0xBB.
        busy_len[0] = 256; busy_len[1] = 1536; busy_len[2] = 512;
        ksa_iso = 1'b1;
        clear_log();
        pulse_en();
        wait_log(0, 3000, "full_run_done_seen");
        ksa_iso = 1'b0;
        check("init_en_latency", en_cyc[0] - acc_cyc, 1);
        check("ksa_en_latency", en_cyc[1] - acc_cyc, 259);
        check("prga_en_latency", en_cyc[2] - acc_cyc, 1797);
        check("done_latency", done_cyc - acc_cyc, 2311);
        check("init_en_count", n_en[0], 1);
        check("ksa_en_count", n_en[1], 1);
        check("prga_en_count", n_en[2], 1);
        check("order_len", order_q.size(), 3);
        if (order_q.size() == 3) begin
            check("order_0", order_q[0], 0);
            check("order_1", order_q[1], 1);
            check("order_2", order_q[2], 2);
        end
        check("ksa_phase_foreign_writes", hit_cnt, 0);
        check("full_run_err", int'(bus.err), 0);
        check("full_run_rdy", int'(bus.rdy), 1);

        // en held high across a whole run and into the next one.
        do_reset();
        busy_len[0] = 3; busy_len[1] = 5; busy_len[2] = 4;
        clear_log();
        en_in = 1'b1;
        wait_log(0, 200, "held_en_done_seen");
        for (int k = 0; k < 10 && n_en[0] < 2; k++) tick(1);
        check("held_en_second_init", n_en[0], 2);
        check("held_en_restart_gap", en_cyc[0] - done_cyc, 1);
        check("held_en_ksa_once", n_en[1], 1);
        check("held_en_prga_once", n_en[2], 1);
        en_in = 1'b0;
        tick(60);

        // KSA never finishes: watchdog, then en is ignored until reset.
        do_reset();
        busy_len[0] = 4; mode[1] = 1;
        clear_log();
        pulse_en();
        wait_log(1, TO + 300, "ksa_stall_err_seen");
        check("ksa_stall_err_delay", err_cyc - en_cyc[1], TO);
        check("ksa_stall_no_prga", n_en[2], 0);
        repeat (3) begin
            en_in = 1'b1; tick(2); en_in = 1'b0; tick(2);
        end
        check("fault_ignores_en", n_en[0], 1);
        check("fault_rdy", int'(bus.rdy), 0);
        check("fault_err", int'(bus.err), 1);
        check("fault_s_wren", int'(bus.s_wren), 0);
        mode[1] = 0;
        do_reset();
        tick(1);
        check("fault_cleared_by_reset", int'(bus.err), 0);

        // Reset mid-KSA aborts the run.
        busy_len[0] = 10; busy_len[1] = 300; busy_len[2] = 10;
        clear_log();
        pulse_en();
        wait_log(2, 100, "abort_ksa_started");
        tick(50);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("abort_rdy", int'(bus.rdy), 1);
        check("abort_done", int'(bus.done), 0);
        check("abort_err", int'(bus.err), 0);
        check("abort_s_wren", int'(bus.s_wren), 0);
        tick(400);
        check("abort_no_prga", n_en[2], 0);

        // Init engine never drops ready after its start pulse.
        do_reset();
        mode[0] = 2;
        clear_log();
        pulse_en();
        wait_log(1, TO + 300, "init_stuck_err_seen");
        check("init_stuck_single_en", n_en[0], 1);
        check("init_stuck_no_ksa", n_en[1], 0);
        check("init_stuck_err_delay", err_cyc - en_cyc[0], TO);
        mode[0] = 0;
        do_reset();

        // Random traffic: jittery readiness, random lengths, random en and occasional resets.
        jitter = 1'b1;
        n_done = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int e = 0; e < 3; e++) busy_len[e] = int'($urandom_range(1, 20));
            en_in = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        en_in = 1'b0;
        check("random_runs_completed", int'(n_done > 0), 1);
        tick(5);

        summary_and_finish();
    end
endmodule

// File: doc/arc4_seq_ctrl.md
Name: arc4_seq_ctrl

Overview:
- Top-level sequencer for the ARC4 datapath.
- Starts the S-array init, KSA and PRGA engines in order, using each engine's rdy/en handshake.
- Arbitrates the single-port S memory so that only the engine currently running drives its address, write data and write enable. The read-data bus fans out directly to all engines.
- Flags a stalled engine with a watchdog, and reports overall ready/done/error to the task-level top.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles an engine may stay busy before the watchdog fires (no sub-phase takes longer than 256*6).
- ADDR_W, 8: S-memory address width.
- DATA_W, 8: S-memory data width.

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- rst_n  in  1  synchronous active-low reset (KEY[3] at top)
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  controller idle and able to accept en
- done  out  1  high from end of a successful run until next accepted en or reset
- err  out  1  watchdog fired; sticky until reset or next accepted en
- init_en  out  1  one-cycle start pulse to the init engine
- init_rdy  in  1  init engine ready
- init_addr  in  ADDR_W  init engine S address
- init_wrdata  in  DATA_W  init engine S write data
- init_wren  in  1  init engine S write enable
- ksa_en, ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren: same as init_*, for the KSA engine
- prga_en, prga_rdy, prga_addr, prga_wrdata, prga_wren: same as init_*, for the PRGA engine
- s_addr  out  ADDR_W  to S memory
- s_wrdata  out  DATA_W  to S memory
- s_wren  out  1  to S memory

Behaviour:
- States: IDLE, INIT_GO, INIT_LO, INIT_HI, KSA_GO, KSA_LO, KSA_HI, PRGA_GO, PRGA_LO, PRGA_HI, FAULT.
- Reset (rst_n=0 at a clk edge, from any state):
  - state=IDLE; rdy=1, done=0, err=0; all *_en=0; watchdog=0.
  - Memory outputs forced to s_addr=0, s_wrdata=0, s_wren=0.
  - Reset mid-run aborts immediately; no further engine pulses are issued.
- IDLE:
  - rdy=1.
  - en=1 takes the controller to INIT_GO next cycle; rdy drops to 0 that same edge; done and err clear.
- X_GO (X = INIT, KSA or PRGA):
  - Waits for X_rdy=1, then asserts X_en for exactly one cycle and moves to X_LO.
  - If X_rdy=0, it holds with X_en=0.
- X_LO: waits for X_rdy=0, confirming the engine took the start. An engine that stays ready counts against the watchdog.
- X_HI: waits for X_rdy=1.
  - INIT_HI goes to KSA_GO.
  - KSA_HI goes to PRGA_GO.
  - PRGA_HI goes to IDLE with done=1 and rdy=1.
- Only one *_en is ever high in a given cycle. No *_en is issued in IDLE or FAULT.
- Watchdog counter:
  - Clears on entry to every X_GO state; increments each cycle in X_GO, X_LO and X_HI.
  - On reaching TIMEOUT_CYCLES-1 the controller goes to FAULT: err=1, rdy=0.
  - FAULT exits only via reset.
- Memory mux:
  - Combinational, selected by registered phase owner (INIT_* owns init, KSA_* owns ksa, PRGA_* owns prga).
  - Zero added latency.
  - Non-owner engines' wren, addr and wrdata are ignored.
  - In IDLE and FAULT: s_wren=0, s_addr=0, s_wrdata=0.
- en while rdy=0 is ignored, not queued.
- en in the same cycle as a PRGA_HI completion is ignored; rdy rises the following cycle.
- Back-to-back runs: en on the cycle after done rises starts a new full sequence and clears done.

Test Plan:
- Stub engines with rdy low for 256, 1536 and 512 cycles; pulse en once -> init_en, ksa_en and prga_en each pulse exactly once, in that order; done=1 and rdy=1 about 2310 cycles later; err=0.
- During the KSA phase, drive init_wren=1 and prga_wren=1 with init_addr=8'hAA and prga_addr=8'hBB -> s_wren, s_addr and s_wrdata track only ksa_*; no write reaches 8'hAA or 8'hBB.
- Hold en=1 for the whole run -> each *_en pulses once per sequence; after done, a second sequence starts one cycle after rdy rises.
- Stub KSA with rdy stuck at 0 (TIMEOUT_CYCLES=64) -> err=1 and FAULT 64 cycles after ksa_en; s_wren=0; no prga_en; en ignored until rst_n=0.
- Assert rst_n=0 for one cycle mid-KSA -> next cycle rdy=1, done=0, err=0, s_wren=0; no prga_en follows.
- Stub init with rdy staying 1 after init_en -> controller holds in INIT_LO; no ksa_en; err=1 at timeout.
